id_ex_stage: RTL
================

# id_ex_stage

Decode/issue stage directly upstream of the ALU. Accepts one RV32I OP (R-type) or OP-IMM (I-type) instruction per cycle through a valid/ready handshake, reads operands from an internal 32x32 register file with write-back bypass, and presents registered `A`, `B`, `ALU_Op` and `Rd` to the ALU. A per-register busy scoreboard stalls issue on RAW and WAW hazards until the matching write-back returns.

## Interface
- `XLEN`, 32: operand and register width.
- `NREGS`, 32: architectural register count. The index width is log2(`NREGS`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `Instr_Valid` in 1: `Instr` holds a valid instruction.
- `Instr` in 32: raw instruction word.
- `Instr_Ready` out 1: stage accepts `Instr` this cycle.
- `Ex_Valid` out 1: outputs below hold an issued instruction.
- `Ex_Ready` in 1: ALU side consumes the issued instruction this cycle.
- `A` out `XLEN`: rs1 value.
- `B` out `XLEN`: rs2 value or immediate.
- `ALU_Op` out 4: ALU operation code.
- `Rd` out 5: destination register.
- `Illegal` out 1: the issued instruction was not OP or OP-IMM.
- `Wb_En` in 1: write-back strobe.
- `Wb_Rd` in 5: write-back register.
- `Wb_Data` in `XLEN`: write-back value.

## Operation
- **`ALU_Op` encoding.** `ALU_Op` = {funct7[5], funct3}.
  - Codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - For OP-IMM, bit 3 = instr[30] only when funct3=101; otherwise bit 3 = 0. ADDI never becomes SUB.
- **Opcodes.**
  - OP = 0110011: `B` = rs2 value.
  - OP-IMM = 0010011: `B` = sign-extended instr[31:20].
  - Any other opcode issues with `Illegal`=1, `ALU_Op`=0000, `Rd`=0, `A`=`B`=0, and makes no scoreboard change.
- **Shifts.** For funct3 001/101, `B[31:5]` is forced to 0, so only shamt / rs2[4:0] reach the ALU.
- **Operand read.** Combinational from the register file. If `Wb_En` is set and `Wb_Rd` equals the source register, `Wb_Data` is bypassed in. Register x0 always reads 0.
- **Register file write.** On `Wb_En` with `Wb_Rd`≠0, the register file is written at the clock edge.
- **Scoreboard.** One busy bit per register; x0 is never busy.
  - Hazard = rs1 busy, OR (OP and rs2 busy), OR (rd≠0 and rd busy).
  - Busy bits are evaluated after the same-cycle clear by `Wb_En`/`Wb_Rd`.
- **Handshake.**
  - `Instr_Ready` = (!`Ex_Valid` | `Ex_Ready`) & !hazard.
  - Transfer occurs when `Instr_Valid` & `Instr_Ready`.
  - On transfer with rd≠0 and a legal opcode, busy[rd] is set.
  - If set and clear of the same register coincide in one cycle, set wins.
- **Output hold.** While `Ex_Valid`=1 and `Ex_Ready`=0, all outputs hold stable.
  - On `Ex_Ready`=1 with no new transfer, `Ex_Valid` falls next cycle.
- **Reset.** Asynchronous reset forces:
  - `Ex_Valid`=0, `A`=`B`=0, `ALU_Op`=0000, `Rd`=0, `Illegal`=0.
  - All busy bits 0 and all registers 0.
  - `Instr_Ready` = 1 on the first cycle after reset release.
  - An in-flight instruction is discarded; no write-back is expected for it.

## Timing
- Issue latency: 1 cycle. Instruction accepted at edge N appears on the outputs with `Ex_Valid`=1 after edge N.
- Sustained throughput: 1 instruction/cycle when independent and `Ex_Ready`=1.
- A dependent instruction issues in the same cycle that its producer's `Wb_En` is asserted, using the bypassed data.
- `Instr_Ready` is combinational from `Instr`, `Wb_*`, `Ex_Ready` and state. It has no dependence on `Instr_Valid`.

## Structure
- Shared package `riscv_pkg`:
  - Opcode constants `OPC_OP` and `OPC_OP_IMM`.
  - `ALU_Op` localparams (`ALU_ADD` … `ALU_AND`).
  - A `reg_idx_t` typedef.
  - The ALU is updated to import the same constants.
- Sub-module `regfile_2r1w`:
  - Two combinational read ports and one synchronous write port.
  - Write-back bypass and x0 handling.
  - Asynchronous active-low clear.
- Decode, scoreboard and the output register live in `id_ex_stage`.

## Test plan
- **Reset.** Reset, then assert `Instr_Valid` with `addi x1,x0,5` and `Ex_Ready`=1.
  - Expect `Ex_Valid`, `A`=0, `B`=5, `ALU_Op`=0000, `Rd`=1 one cycle later.
  - Expect busy[1]=1.
- **RAW stall and release.**
  - Issue `addi x1,x0,5` and then `add x2,x1,x1`: `Instr_Ready`=0 until `Wb_En`/`Wb_Rd`=1/`Wb_Data`=5.
  - In the write-back cycle `Instr_Ready`=1; the next cycle shows `A`=`B`=5, `ALU_Op`=0000, `Rd`=2.
- **Decode coverage.** Issue `sub`, `sra`, `srai x3,x4,31`, `addi` with imm=-1 and `slli` with imm bit 30 clear.
  - `ALU_Op` 1000, 1101, 1101, 0000, 0001.
  - `srai` gives `B`=31; `addi` gives `B`=0xFFFFFFFF.
  - A shift with rs2=0x00000123 gives `B`=3.
- **Backpressure.** Hold `Ex_Ready`=0 with `Ex_Valid`=1 for 3 cycles.
  - Outputs stable and `Instr_Ready`=0.
  - Release: the next queued instruction appears the following cycle with no gap.
- **Illegal and x0.**
  - Instruction 0x0000006F (JAL) issues with `Illegal`=1, `Rd`=0 and no busy change.
  - `addi x0,x0,7` sets no busy bit, and a following `add x5,x0,x0` issues back-to-back.
- **Reset mid-operation.** Assert `rst_n`=0 while `Ex_Valid`=1 and busy[1]=1.
  - Outputs and busy clear asynchronously.
  - After release, `add x2,x1,x1` issues immediately with `A`=`B`=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants used by the issue stage and the ALU.
package riscv_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned ALU_W = 4;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational reads with write-back bypass, one synchronous write.
module regfile_2r1w
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  reg_idx_t        i_rs1,
  input  reg_idx_t        i_rs2,
  output logic [XLEN-1:0] o_rs1_data_c,
  output logic [XLEN-1:0] o_rs2_data_c,
  input  logic            i_we,
  input  reg_idx_t        i_waddr,
  input  logic [XLEN-1:0] i_wdata
);

  logic [XLEN-1:0] r_mem [NREGS];

  // Storage; x0 is never written and is cleared on reset with the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port 1: x0 reads zero, a same-cycle write-back is forwarded.
  always_comb begin
    o_rs1_data_c = r_mem[i_rs1];
    if (i_rs1 == '0)                   o_rs1_data_c = '0;
    else if (i_we && (i_waddr == i_rs1)) o_rs1_data_c = i_wdata;
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    o_rs2_data_c = r_mem[i_rs2];
    if (i_rs2 == '0)                   o_rs2_data_c = '0;
    else if (i_we && (i_waddr == i_rs2)) o_rs2_data_c = i_wdata;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage: decodes OP/OP-IMM, tracks RAW/WAW hazards, registers ALU operands.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Instr_Valid,
  input  logic [31:0]     Instr,
  output logic            Instr_Ready,
  output logic            Ex_Valid,
  input  logic            Ex_Ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALU_Op,
  output logic [4:0]      Rd,
  output logic            Illegal,
  input  logic            Wb_En,
  input  logic [4:0]      Wb_Rd,
  input  logic [XLEN-1:0] Wb_Data
);

  logic [OPC_W-1:0] w_opcode;
  reg_idx_t         w_rd, w_rs1, w_rs2;
  logic [2:0]       w_f3;
  logic             w_is_op, w_is_imm, w_legal, w_is_shift;
  logic [XLEN-1:0]  w_rs1_data, w_rs2_data;
  logic [XLEN-1:0]  w_a, w_b;
  logic [3:0]       w_op;
  reg_idx_t         w_dst;
  logic [NREGS-1:0] w_clr_mask, w_set_mask, w_busy_eff, w_busy_nxt;
  logic             w_hazard, w_xfer;

  logic [NREGS-1:0] r_busy;
  logic             r_ex_valid;
  logic [XLEN-1:0]  r_a, r_b;
  logic [3:0]       r_op;
  reg_idx_t         r_rd;
  logic             r_ill;

  assign w_opcode   = Instr[6:0];
  assign w_rd       = Instr[11:7];
  assign w_f3       = Instr[14:12];
  assign w_rs1      = Instr[19:15];
  assign w_rs2      = Instr[24:20];
  assign w_is_op    = (w_opcode == OPC_OP);
  assign w_is_imm   = (w_opcode == OPC_OP_IMM);
  assign w_legal    = w_is_op | w_is_imm;
  assign w_is_shift = (w_f3 == F3_SLL) | (w_f3 == F3_SR);

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rs1        (w_rs1),
    .i_rs2        (w_rs2),
    .o_rs1_data_c (w_rs1_data),
    .o_rs2_data_c (w_rs2_data),
    .i_we         (Wb_En),
    .i_waddr      (Wb_Rd),
    .i_wdata      (Wb_Data)
  );

  // Scoreboard view after this cycle's write-back clear, hazard and handshake.
  always_comb begin
    w_clr_mask  = Wb_En ? (NREGS'(1) << Wb_Rd) : '0;
    w_busy_eff  = r_busy & ~w_clr_mask;
    w_hazard    = w_busy_eff[w_rs1]
                | (w_is_op & w_busy_eff[w_rs2])
                | ((w_rd != '0) & w_busy_eff[w_rd]);
    Instr_Ready = (~r_ex_valid | Ex_Ready) & ~w_hazard;
    w_xfer      = Instr_Valid & Instr_Ready;
    w_set_mask  = (w_xfer && w_legal && (w_rd != '0)) ? (NREGS'(1) << w_rd) : '0;
    w_busy_nxt  = w_busy_eff | w_set_mask;
  end

  // Operand and opcode decode; illegal opcodes collapse to all-zero fields.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_op  = ALU_ADD;
    w_dst = '0;
    if (w_is_op) begin
      w_a   = w_rs1_data;
      w_b   = w_rs2_data;
      w_op  = {Instr[30], w_f3};
      w_dst = w_rd;
    end else if (w_is_imm) begin
      w_a   = w_rs1_data;
      w_b   = {{(XLEN-12){Instr[31]}}, Instr[31:20]};
      w_op  = {(w_f3 == F3_SR) & Instr[30], w_f3};
      w_dst = w_rd;
    end
    if (w_legal && w_is_shift) w_b = w_b & XLEN'(31);
  end

  // Issue register and busy bits; outputs hold while the ALU stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_ex_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= ALU_ADD;
      r_rd       <= '0;
      r_ill      <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_xfer) begin
        r_ex_valid <= 1'b1;
        r_a        <= w_a;
        r_b        <= w_b;
        r_op       <= w_op;
        r_rd       <= w_dst;
        r_ill      <= ~w_legal;
      end else if (Ex_Ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign Ex_Valid = r_ex_valid;
  assign A        = r_a;
  assign B        = r_b;
  assign ALU_Op   = r_op;
  assign Rd       = r_rd;
  assign Illegal  = r_ill;

endmodule
